add3_arbiter: RTL and testbench
===============================

ADD3_ARBITER -- requirements
Module: add3_arbiter

Interface
REQ-001 Parameter: W, 8, operand width in bits; result width is W+2.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req0_valid  input  1  requester 0 holds a triplet.
REQ-005 req0_data  input  3*W  requester 0 operands {c,b,a}, a in [W-1:0].
REQ-006 req0_ready  output  1  requester 0 triplet accepted this cycle when high with req0_valid.
REQ-007 req1_valid, req1_data, req1_ready  as REQ-004..006 for requester 1.
REQ-008 res_valid  output  1  result available.
REQ-009 res_ready  input  1  consumer accepts result.
REQ-010 res_data  output  W+2  a+b+c of the served triplet.
REQ-011 res_id  output  1  index of the requester that produced res_data.
REQ-012 ops_done  output  16  count of results delivered.

Function
REQ-013 The block SHALL share one registered 3-input W-bit adder between two requesters using an FSM with states IDLE, ADD, HOLD.
REQ-014 IDLE: reqN_ready SHALL be combinationally high only for the granted requester; both readies low in ADD and HOLD.
REQ-015 Grant: only one valid -> that one; both valid -> requester other than last_served; last_served resets to 1, so req0 wins the first tie.
REQ-016 Accept (valid&ready in IDLE): latch operands and id, update last_served, go to ADD next cycle.
REQ-017 ADD: res_data <= a+b+c zero-extended to W+2 bits, no truncation or saturation; res_id <= latched id; res_valid <= 1; go to HOLD.
REQ-018 Latency: res_valid SHALL rise exactly 2 clk edges after the accepting edge.
REQ-019 HOLD: res_data, res_id, res_valid SHALL stay stable until res_valid&res_ready; on that edge res_valid <= 0, ops_done increments, state -> IDLE.
REQ-020 Next accept earliest in the cycle after the result handshake (one triplet in flight; no overlap).
REQ-021 ops_done SHALL wrap 16'hFFFF -> 0.
REQ-022 reqN_data changes while not accepted SHALL have no effect; a requester dropping valid before acceptance loses no state.
REQ-023 res_ready high in IDLE or ADD SHALL have no effect.

Reset
REQ-024 rst_n low SHALL immediately force state=IDLE, res_valid=0, res_data=0, res_id=0, ops_done=0, last_served=1, latched operands=0, regardless of state.
REQ-025 Reset mid-ADD/HOLD SHALL discard the in-flight triplet with no result produced and no ops_done increment.
REQ-026 After rst_n deasserts, first acceptance possible on the first rising edge with rst_n high.

Verification
REQ-027 req0 {3,2,1}, res_ready=1 -> res_valid 2 edges after accept, res_data=6, res_id=0, ops_done=1.
REQ-028 req1 {255,255,255} -> res_data=765 (10'h2FD), res_id=1; no overflow.
REQ-029 Both valid continuously, res_ready=1 -> res_id sequence 0,1,0,1; accept every 3 cycles.
REQ-030 res_ready=0 for 5 cycles in HOLD -> res_valid, res_data, res_id constant; readies low; no new accept.
REQ-031 rst_n low during HOLD -> res_valid, res_data, ops_done = 0 asynchronously; post-reset tie grants req0.
REQ-032 Preload 65535 results -> next delivered result makes ops_done=0.

Source files
------------

// File: rtl/add3_arbiter.sv
// add3_arbiter: two requesters share one registered 3-input adder.
// Round-robin tie-break, one triplet in flight, delivered-result counter.
module add3_arbiter #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  input  logic [3*W-1:0] req0_data,
  output logic           req0_ready,
  input  logic           req1_valid,
  input  logic [3*W-1:0] req1_data,
  output logic           req1_ready,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [W+1:0]   res_data,
  output logic           res_id,
  output logic [15:0]    ops_done
);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    HOLD
  } state_e;

  state_e         state_q, state_d;
  logic           last_q, last_d;
  logic           id_q, id_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   c_q, c_d;
  logic [W+1:0]   rdata_q, rdata_d;
  logic           rvalid_q, rvalid_d;
  logic           rid_q, rid_d;
  logic [15:0]    ops_q, ops_d;

  logic gnt0, gnt1;
  logic acc0, acc1;
  logic in_add, fire;

  // On a tie the requester not served last wins
  assign gnt0 = req0_valid & (~req1_valid | last_q);
  assign gnt1 = req1_valid & (~req0_valid | ~last_q);

  assign acc0   = req0_ready & req0_valid;
  assign acc1   = req1_ready & req1_valid;
  assign in_add = (state_q == ADD);
  assign fire   = (state_q == HOLD) & rvalid_q & res_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (acc0 | acc1) state_d = ADD;
      ADD:     state_d = HOLD;
      HOLD:    if (fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Readies only while idle, and only toward the granted side
  always_comb begin
    req0_ready = (state_q == IDLE) & gnt0;
    req1_ready = (state_q == IDLE) & gnt1;
  end

  // Datapath next-state: latch, add, release
  always_comb begin
    last_d   = last_q;
    id_d     = id_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    rdata_d  = rdata_q;
    rvalid_d = rvalid_q;
    rid_d    = rid_q;
    ops_d    = ops_q;
    unique case (1'b1)
      acc0: begin
        a_d    = req0_data[W-1:0];
        b_d    = req0_data[2*W-1:W];
        c_d    = req0_data[3*W-1:2*W];
        id_d   = 1'b0;
        last_d = 1'b0;
      end
      acc1: begin
        a_d    = req1_data[W-1:0];
        b_d    = req1_data[2*W-1:W];
        c_d    = req1_data[3*W-1:2*W];
        id_d   = 1'b1;
        last_d = 1'b1;
      end
      in_add: begin
        rdata_d  = {2'b00, a_q}
                 + {2'b00, b_q}
                 + {2'b00, c_q};
        rid_d    = id_q;
        rvalid_d = 1'b1;
      end
      fire: begin
        rvalid_d = 1'b0;
        ops_d    = ops_q + 16'd1;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q   <= 1'b1;
      id_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rid_q    <= 1'b0;
      ops_q    <= '0;
    end else begin
      last_q   <= last_d;
      id_q     <= id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rid_q    <= rid_d;
      ops_q    <= ops_d;
    end
  end

  assign res_valid = rvalid_q;
  assign res_data  = rdata_q;
  assign res_id    = rid_q;
  assign ops_done  = ops_q;

endmodule

// File: tb/tb_add3_arbiter.sv
// tb_add3_arbiter: directed + random checks of add3_arbiter
// against a transaction-level reference model.
module tb_add3_arbiter;

  logic        clk;
  logic        rst_n;
  logic        v0, v1, rr;
  logic [23:0] d0, d1;
  logic        req0_ready, req1_ready;
  logic        res_valid, res_id;
  logic [9:0]  res_data;
  logic [15:0] ops_done;

  int tests = 0;
  int fails = 0;

  // reference model state
  logic        m_last;
  logic        m_infl;
  logic        m_shown;
  logic        m_id;
  int          m_sum;
  logic        m_rv;
  int          m_rd;
  logic        m_ri;
  logic [15:0] m_ops;

  add3_arbiter #(.W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (v0),
    .req0_data  (d0),
    .req0_ready (req0_ready),
    .req1_valid (v1),
    .req1_data  (d1),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_ready  (rr),
    .res_data   (res_data),
    .res_id     (res_id),
    .ops_done   (ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sum3(input logic [23:0] d);
    return int'(d[7:0]) + int'(d[15:8]) + int'(d[23:16]);
  endfunction

  task automatic m_reset();
    m_last  = 1'b1;
    m_infl  = 1'b0;
    m_shown = 1'b0;
    m_id    = 1'b0;
    m_sum   = 0;
    m_rv    = 1'b0;
    m_rd    = 0;
    m_ri    = 1'b0;
    m_ops   = 16'd0;
  endtask

  task automatic chk_out();
    chk("res_valid", res_valid, m_rv);
    chk("res_data", res_data, m_rd);
    chk("res_id", res_id, m_ri);
    chk("ops_done", ops_done, m_ops);
  endtask

  // one clock cycle: drive, check readies, clock, advance model, check
  task automatic cyc(input logic iv0, input logic [23:0] id0,
                     input logic iv1, input logic [23:0] id1,
                     input logic irr);
    logic g0, g1;
    v0 = iv0; d0 = id0;
    v1 = iv1; d1 = id1;
    rr = irr;
    g0 = iv0 && (!iv1 || m_last);
    g1 = iv1 && (!iv0 || !m_last);
    #1;
    chk("rdy0", req0_ready, !m_infl && g0);
    chk("rdy1", req1_ready, !m_infl && g1);
    @(posedge clk);
    if (!m_infl) begin
      if (g0 || g1) begin
        m_infl  = 1'b1;
        m_shown = 1'b0;
        m_id    = g1;
        m_sum   = g1 ? sum3(id1) : sum3(id0);
        m_last  = g1;
      end
    end else if (!m_shown) begin
      m_shown = 1'b1;
      m_rv    = 1'b1;
      m_rd    = m_sum;
      m_ri    = m_id;
    end else if (irr) begin
      m_rv   = 1'b0;
      m_infl = 1'b0;
      m_ops  = m_ops + 16'd1;
    end
    #1;
    chk_out();
  endtask

  initial begin
    logic        ids[$];
    int          pos[$];
    logic [9:0]  hd;
    logic        hi;

    rst_n = 1'b0;
    v0 = 1'b0; v1 = 1'b0; rr = 1'b0;
    d0 = '0; d1 = '0;
    m_reset();
    #2;
    chk_out();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // idle: no valids, nothing granted
    cyc(0, 24'h0, 0, 24'h0, 1);

    // basic add, latency, counter
    cyc(1, 24'h030201, 0, 24'h0, 1);
    chk("r27_lat", res_valid, 1'b0);
    cyc(0, 24'h0, 0, 24'h0, 1);
    chk("r27_v", res_valid, 1'b1);
    chk("r27_data", res_data, 10'd6);
    chk("r27_id", res_id, 1'b0);
    cyc(0, 24'h0, 0, 24'h0, 1);
    chk("r27_ops", ops_done, 16'd1);

    // widest operands, no overflow
    cyc(0, 24'h0, 1, 24'hFFFFFF, 1);
    cyc(0, 24'h0, 0, 24'h0, 1);
    chk("r28_data", res_data, 10'h2FD);
    chk("r28_id", res_id, 1'b1);
    cyc(0, 24'h0, 0, 24'h0, 1);

    // continuous contention alternates
    for (int i = 0; i < 12; i++) begin
      cyc(1, 24'h010101, 1, 24'h020202, 1);
      if (res_valid) begin
        ids.push_back(res_id);
        pos.push_back(i);
      end
    end
    chk("r29_n", ids.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < ids.size()) begin
        chk("r29_id", ids[i], i % 2);
        chk("r29_pos", pos[i], 1 + 3 * i);
      end
    end

    // back-pressure in HOLD
    cyc(1, 24'h102030, 1, 24'h405060, 0);
    cyc(1, 24'h0A0B0C, 1, 24'h0D0E0F, 0);
    hd = res_data;
    hi = res_id;
    chk("r30_data0", hd, 10'h60);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 24'($urandom), 1, 24'($urandom), 0);
      chk("r30_v", res_valid, 1'b1);
      chk("r30_d", res_data, hd);
      chk("r30_i", res_id, hi);
    end

    // async reset during HOLD
    rst_n = 1'b0;
    #1;
    m_reset();
    chk_out();
    #2;
    rst_n = 1'b1;
    cyc(1, 24'h000102, 1, 24'h000304, 1);
    cyc(0, 24'h0, 0, 24'h0, 1);
    chk("r31_id", res_id, 1'b0);
    chk("r31_d", res_data, 10'd3);
    cyc(0, 24'h0, 0, 24'h0, 1);

    // counter wrap from preloaded 16'hFFFF
    v0 = 1'b0; v1 = 1'b0; rr = 1'b0;
    force dut.ops_d = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.ops_d;
    m_ops = 16'hFFFF;
    chk("r32_pre", ops_done, 16'hFFFF);
    cyc(0, 24'h0, 1, 24'h010203, 1);
    cyc(0, 24'h0, 0, 24'h0, 1);
    cyc(0, 24'h0, 0, 24'h0, 1);
    chk("r32_wrap", ops_done, 16'h0000);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      cyc(1'($urandom_range(0, 1)), 24'($urandom),
          1'($urandom_range(0, 1)), 24'($urandom),
          ($urandom_range(0, 9) < 7));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
